// File: rtl/prog_loader.sv
// -----------------------------------------------------------------------------
// prog_loader
//
// Front-end that feeds a program image into the cpu block and then services
// the cpu's WRIM input requests while the program runs.
//
// A valid/ready byte stream supplies the image. Each image byte goes through
// the cpu's level-sensitive load handshake: first the RAM address on o_data
// with o_load_addr high, then the byte on o_data with o_load_data high. After
// the last byte the loader pulses o_execute. It then waits in RUN. A WRIM
// request (waiting && take_input) is answered with the next stream byte and an
// o_input_taken pulse. When the cpu halts (waiting && !take_input), o_done
// pulses for one cycle and the loader returns to idle.
//
// Parameters:
//   HOLD_CYCLES      cycles each strobe (load_addr/load_data/execute/
//                    input_taken) stays high; legal range 1..15
//
// Ports:
//   i_clk            clock
//   i_reset          synchronous, active-high reset; aborts a session
//   i_start          one-cycle session request, honoured only when idle
//   i_base_addr      RAM address of the first image byte (sampled with start)
//   i_len            image length 0..256 (sampled with start)
//   i_byte_valid     stream byte available
//   i_byte           stream byte
//   o_byte_ready     stream byte accepted when i_byte_valid && o_byte_ready
//   i_cpu_waiting    cpu o_waiting
//   i_cpu_take_input cpu o_take_input
//   o_load_addr      to cpu i_load_addr
//   o_load_data      to cpu i_load_data
//   o_execute        to cpu i_execute
//   o_input_taken    to cpu i_input_taken
//   o_data           to cpu i_data_in; keeps its value until the next byte is
//                    captured
//   o_busy           session in progress
//   o_done           one-cycle pulse when the cpu halts
//
// Optional feature (macro PROG_LOADER_CHECKSUM_EN):
//   o_checksum       mod-256 sum of the image bytes accepted in the load phase.
//                    It is cleared on reset and on an accepted start.
// -----------------------------------------------------------------------------
module prog_loader #(
  parameter int HOLD_CYCLES = 2
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_start,
  input  logic [7:0] i_base_addr,
  input  logic [8:0] i_len,
  input  logic       i_byte_valid,
  input  logic [7:0] i_byte,
  output logic       o_byte_ready,
  input  logic       i_cpu_waiting,
  input  logic       i_cpu_take_input,
  output logic       o_load_addr,
  output logic       o_load_data,
  output logic       o_execute,
  output logic       o_input_taken,
  output logic [7:0] o_data,
  output logic       o_busy,
  output logic       o_done
`ifdef PROG_LOADER_CHECKSUM_EN
  ,
  output logic [7:0] o_checksum
`endif
);

  typedef enum logic [3:0] {
    S_IDLE,     // no session
    S_A_WAIT,   // address on o_data, waiting for the cpu to accept a load
    S_A_HOLD,   // o_load_addr strobe
    S_B_FETCH,  // pull one image byte from the stream
    S_D_WAIT,   // waiting for the cpu to ask for the data byte
    S_D_HOLD,   // o_load_data strobe
    S_X_WAIT,   // image complete, waiting for the cpu to be idle
    S_X_HOLD,   // o_execute strobe
    S_RUN,      // program running, serving WRIM or detecting halt
    S_R_FETCH,  // WRIM pending, pulling one input byte from the stream
    S_I_HOLD,   // o_input_taken strobe
    S_I_WAIT    // waiting for the cpu to withdraw the WRIM request
  } state_e;

  localparam logic [3:0] HOLD_LAST = 4'(HOLD_CYCLES - 1);

  // cpu status decode
  logic load_ready, data_ready, wrim_ready;
  assign load_ready = i_cpu_waiting  && !i_cpu_take_input;
  assign data_ready = !i_cpu_waiting && i_cpu_take_input;
  assign wrim_ready = i_cpu_waiting  && i_cpu_take_input;

  state_e     state_q, state_d;
  logic [7:0] base_q, base_d;
  logic [8:0] len_q, len_d;
  logic [8:0] idx_q, idx_d;
  logic [3:0] hc_q, hc_d;
  logic [7:0] data_q, data_d;
  logic       done_q, done_d;
  logic       byte_ready_q, byte_ready_d;
  logic       load_addr_q, load_addr_d;
  logic       load_data_q, load_data_d;
  logic       execute_q, execute_d;
  logic       input_taken_q, input_taken_d;
  logic       busy_q, busy_d;
`ifdef PROG_LOADER_CHECKSUM_EN
  logic [7:0] csum_q, csum_d;
`endif

  // The registered o_byte_ready qualifies acceptance. The downstream
  // handshake therefore sees the same ready that leaves the block.
  logic accept;
  assign accept = i_byte_valid && byte_ready_q;

  logic hold_done;
  assign hold_done = (hc_q == HOLD_LAST);

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  // NOTE: every flop is updated with <= so all registers sample the same
  // pre-edge values; blocking assignments here would order-couple them.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q       <= S_IDLE;
      base_q        <= '0;
      len_q         <= '0;
      idx_q         <= '0;
      hc_q          <= '0;
      data_q        <= '0;
      done_q        <= 1'b0;
      byte_ready_q  <= 1'b0;
      load_addr_q   <= 1'b0;
      load_data_q   <= 1'b0;
      execute_q     <= 1'b0;
      input_taken_q <= 1'b0;
      busy_q        <= 1'b0;
`ifdef PROG_LOADER_CHECKSUM_EN
      csum_q        <= '0;
`endif
    end else begin
      state_q       <= state_d;
      base_q        <= base_d;
      len_q         <= len_d;
      idx_q         <= idx_d;
      hc_q          <= hc_d;
      data_q        <= data_d;
      done_q        <= done_d;
      byte_ready_q  <= byte_ready_d;
      load_addr_q   <= load_addr_d;
      load_data_q   <= load_data_d;
      execute_q     <= execute_d;
      input_taken_q <= input_taken_d;
      busy_q        <= busy_d;
`ifdef PROG_LOADER_CHECKSUM_EN
      csum_q        <= csum_d;
`endif
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state and datapath
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: defaults first, so every path assigns every signal and no latch
    // is inferred.
    state_d = state_q;
    base_d  = base_q;
    len_d   = len_q;
    idx_d   = idx_q;
    hc_d    = '0;     // hold counter is zero outside the hold states
    data_d  = data_q;
    done_d  = 1'b0;
`ifdef PROG_LOADER_CHECKSUM_EN
    csum_d  = csum_q;
`endif

    unique case (state_q)
      S_IDLE: begin
        if (i_start) begin
          base_d = i_base_addr;
          len_d  = i_len;
          idx_d  = '0;
`ifdef PROG_LOADER_CHECKSUM_EN
          csum_d = '0;
`endif
          if (i_len == 9'd0) begin
            state_d = S_X_WAIT;
          end else begin
            state_d = S_A_WAIT;
            data_d  = i_base_addr;          // address of byte 0
          end
        end
      end

      S_A_WAIT: begin
        if (load_ready) state_d = S_A_HOLD;
      end

      S_A_HOLD: begin
        if (hold_done) state_d = S_B_FETCH;
        else           hc_d    = hc_q + 4'd1;
      end

      S_B_FETCH: begin
        if (accept) begin
          data_d  = i_byte;
          state_d = S_D_WAIT;
`ifdef PROG_LOADER_CHECKSUM_EN
          csum_d  = csum_q + i_byte;
`endif
        end
      end

      S_D_WAIT: begin
        if (data_ready) state_d = S_D_HOLD;
      end

      S_D_HOLD: begin
        if (hold_done) begin
          idx_d = idx_q + 9'd1;
          if (idx_d == len_q) begin
            state_d = S_X_WAIT;
          end else begin
            state_d = S_A_WAIT;
            // 8-bit add wraps 8'hFF -> 8'h00 for images crossing the top.
            data_d  = base_q + idx_d[7:0];
          end
        end else begin
          hc_d = hc_q + 4'd1;
        end
      end

      S_X_WAIT: begin
        if (load_ready) state_d = S_X_HOLD;
      end

      S_X_HOLD: begin
        if (hold_done) state_d = S_RUN;
        else           hc_d    = hc_q + 4'd1;
      end

      S_RUN: begin
        if (wrim_ready) begin
          state_d = S_R_FETCH;
        end else if (load_ready) begin
          done_d  = 1'b1;
          state_d = S_IDLE;
        end
      end

      S_R_FETCH: begin
        if (accept) begin
          data_d  = i_byte;
          state_d = S_I_HOLD;
        end else if (!wrim_ready) begin
          state_d = S_RUN;                  // request withdrawn, nothing taken
        end
      end

      S_I_HOLD: begin
        if (hold_done) state_d = S_I_WAIT;
        else           hc_d    = hc_q + 4'd1;
      end

      S_I_WAIT: begin
        // The cpu must drop the request before another byte is served.
        // Otherwise a slow cpu would get the same WRIM answered twice.
        if (!wrim_ready) state_d = S_RUN;
      end

      default: state_d = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Output decode
  // ---------------------------------------------------------------------------
  // The outputs are decoded from the next state and then registered. Each
  // strobe is therefore high exactly while the state register holds its hold
  // state, and only one strobe can be high at a time.
  always_comb begin
    byte_ready_d  = (state_d == S_B_FETCH) || (state_d == S_R_FETCH);
    load_addr_d   = (state_d == S_A_HOLD);
    load_data_d   = (state_d == S_D_HOLD);
    execute_d     = (state_d == S_X_HOLD);
    input_taken_d = (state_d == S_I_HOLD);
    busy_d        = (state_d != S_IDLE);
  end

  assign o_byte_ready  = byte_ready_q;
  assign o_load_addr   = load_addr_q;
  assign o_load_data   = load_data_q;
  assign o_execute     = execute_q;
  assign o_input_taken = input_taken_q;
  assign o_data        = data_q;
  assign o_busy        = busy_q;
  assign o_done        = done_q;
`ifdef PROG_LOADER_CHECKSUM_EN
  assign o_checksum    = csum_q;
`endif

endmodule

// File: tb/tb_prog_loader.sv
// -----------------------------------------------------------------------------
// tb_prog_loader
//
// The bench holds a behavioural cpu with a 256-byte RAM that answers the
// load/execute/WRIM handshake, and a stream source fed from a queue. A
// negedge monitor records every load write (address, data) and every WRIM
// byte into observation queues. Each test pushes its expected writes when it
// drives the stimulus. At the end of the session the test pops both queues
// and compares them, and it also checks the cpu RAM, the strobe pulse counts
// and widths, and the o_done and o_busy behaviour.
// -----------------------------------------------------------------------------
module tb_prog_loader;

  localparam int HOLD = 2;

  logic       i_clk = 1'b0;
  logic       i_reset = 1'b1;
  logic       i_start = 1'b0;
  logic [7:0] i_base_addr = '0;
  logic [8:0] i_len = '0;
  logic       i_byte_valid = 1'b0;
  logic [7:0] i_byte = '0;
  logic       o_byte_ready;
  logic       i_cpu_waiting = 1'b1;
  logic       i_cpu_take_input = 1'b0;
  logic       o_load_addr, o_load_data, o_execute, o_input_taken;
  logic [7:0] o_data;
  logic       o_busy, o_done;
`ifdef PROG_LOADER_CHECKSUM_EN
  logic [7:0] o_checksum;
`endif

  prog_loader #(.HOLD_CYCLES(HOLD)) dut (
    .i_clk(i_clk), .i_reset(i_reset), .i_start(i_start),
    .i_base_addr(i_base_addr), .i_len(i_len),
    .i_byte_valid(i_byte_valid), .i_byte(i_byte), .o_byte_ready(o_byte_ready),
    .i_cpu_waiting(i_cpu_waiting), .i_cpu_take_input(i_cpu_take_input),
    .o_load_addr(o_load_addr), .o_load_data(o_load_data),
    .o_execute(o_execute), .o_input_taken(o_input_taken),
    .o_data(o_data), .o_busy(o_busy), .o_done(o_done)
`ifdef PROG_LOADER_CHECKSUM_EN
    , .o_checksum(o_checksum)
`endif
  );

  always #5 i_clk = ~i_clk;

  int n_checks = 0;
  int n_pass   = 0;

  // ---------------- stream source ----------------
  typedef struct { logic [7:0] b; int delay; } sbyte_t;
  sbyte_t stream_q[$];
  int take_cnt = 0;
  int seen_cnt = 0;

  always @(posedge i_clk)
    if (!i_reset && i_byte_valid && o_byte_ready) take_cnt++;

  always @(negedge i_clk) begin
    if (take_cnt != seen_cnt) begin
      seen_cnt = take_cnt;
      if (stream_q.size() > 0) void'(stream_q.pop_front());
    end
    if (i_reset || stream_q.size() == 0) begin
      i_byte_valid = 1'b0;
    end else if (stream_q[0].delay > 0) begin
      stream_q[0].delay = stream_q[0].delay - 1;
      i_byte_valid = 1'b0;
    end else begin
      i_byte_valid = 1'b1;
      i_byte       = stream_q[0].b;
    end
  end

  // ---------------- behavioural cpu ----------------
  typedef enum {C_LOAD, C_LA, C_DATA, C_LD, C_EX, C_RUN, C_WRIM, C_WT} cst_e;
  cst_e       cst = C_LOAD;
  logic [7:0] cpu_ram [256];
  logic [7:0] cpu_addr = '0, cpu_pc = '0, cpu_opnd = '0;
  int         halt_cnt = 0;
  bit         clr_ram_on_reset = 1'b1;

  always @(negedge i_clk) begin
    if (i_reset) begin
      cst = C_LOAD; i_cpu_waiting = 1'b1; i_cpu_take_input = 1'b0;
      if (clr_ram_on_reset) for (int i = 0; i < 256; i++) cpu_ram[i] = 8'h00;
    end else begin
      case (cst)
        C_LOAD:
          if (o_load_addr) begin
            cpu_addr = o_data; i_cpu_waiting = 1'b0; cst = C_LA;
          end else if (o_execute) begin
            i_cpu_waiting = 1'b0; cst = C_EX;
          end
        C_LA:   if (!o_load_addr) begin i_cpu_take_input = 1'b1; cst = C_DATA; end
        C_DATA: if (o_load_data) begin
                  cpu_ram[cpu_addr] = o_data; i_cpu_take_input = 1'b0; cst = C_LD;
                end
        C_LD:   if (!o_load_data) begin i_cpu_waiting = 1'b1; cst = C_LOAD; end
        C_EX:   if (!o_execute) begin cpu_pc = 8'h00; cst = C_RUN; end
        C_RUN:
          if (cpu_ram[cpu_pc] == 8'h00) begin             // halt
            i_cpu_waiting = 1'b1; i_cpu_take_input = 1'b0; halt_cnt++; cst = C_LOAD;
          end else if (cpu_ram[cpu_pc] == 8'h02) begin    // WRIM addr
            cpu_opnd = cpu_ram[cpu_pc + 8'd1];
            i_cpu_waiting = 1'b1; i_cpu_take_input = 1'b1; cst = C_WRIM;
          end else begin
            cpu_pc = cpu_pc + 8'd1;
          end
        C_WRIM: if (o_input_taken) begin
                  cpu_ram[cpu_opnd] = o_data;
                  i_cpu_waiting = 1'b0; i_cpu_take_input = 1'b0; cst = C_WT;
                end
        C_WT:   if (!o_input_taken) begin cpu_pc = cpu_pc + 8'd2; cst = C_RUN; end
        default: cst = C_LOAD;
      endcase
    end
  end

  // ---------------- monitor ----------------
  typedef struct packed { logic [7:0] a; logic [7:0] d; } ld_t;
  ld_t        exp_load[$], obs_load[$];
  logic [7:0] exp_in[$], obs_in[$];
  int   pulse_cnt [4] = '{0, 0, 0, 0};   // load_addr, load_data, execute, input_taken
  int   run_len   [4] = '{0, 0, 0, 0};
  int   width_err = 0, onehot_err = 0, unstable_err = 0, ready_cnt = 0, done_cnt = 0;
  logic [3:0] prev = '0;
  logic [7:0] la_addr = '0;

  always @(negedge i_clk) begin : mon
    logic [3:0] s;
    s = {o_input_taken, o_execute, o_load_data, o_load_addr};
    if (i_reset) begin
      prev = '0;
      for (int i = 0; i < 4; i++) run_len[i] = 0;
    end else begin
      if ($countones(s) > 1) onehot_err++;
      if (s[0] && !prev[0]) la_addr = o_data;
      if (s[0] && prev[0] && o_data !== la_addr) unstable_err++;
      if (s[1] && !prev[1]) obs_load.push_back({la_addr, o_data});
      if (s[3] && !prev[3]) obs_in.push_back(o_data);
      for (int i = 0; i < 4; i++) begin
        if (s[i]) run_len[i]++;
        else if (prev[i]) begin
          pulse_cnt[i]++;
          if (run_len[i] != HOLD) width_err++;
          run_len[i] = 0;
        end
      end
      if (o_byte_ready) ready_cnt++;
      if (o_done) done_cnt++;
      prev = s;
    end
  end

  // ---------------- stimulus helpers (no checking) ----------------
  task automatic tick(input int n);
    repeat (n) begin @(posedge i_clk); #1; end
  endtask

  task automatic do_reset();
    i_reset = 1'b1; i_start = 1'b0;
    stream_q.delete();
    tick(2);
    exp_load.delete(); obs_load.delete(); exp_in.delete(); obs_in.delete();
    i_reset = 1'b0;
    tick(1);
  endtask

  task automatic start_session(input logic [7:0] base, input logic [8:0] len);
    i_base_addr = base; i_len = len; i_start = 1'b1;
    tick(1);
    i_start = 1'b0;
  endtask

  task automatic wait_done(input int budget, output bit ok);
    ok = 1'b0;
    repeat (budget) begin
      tick(1);
      if (o_done) begin ok = 1'b1; break; end
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    do_reset();
    n_checks++;
    if ({o_byte_ready, o_load_addr, o_load_data, o_execute, o_input_taken, o_busy, o_done} !== 7'b0)
      $display("FAIL reset_ctrl: got %b want 0000000",
               {o_byte_ready, o_load_addr, o_load_data, o_execute, o_input_taken, o_busy, o_done});
    else n_pass++;
    n_checks++;
    if (o_data !== 8'h00) $display("FAIL reset_data: got %h want 00", o_data); else n_pass++;
`ifdef PROG_LOADER_CHECKSUM_EN
    n_checks++;
    if (o_checksum !== 8'h00) $display("FAIL reset_csum: got %h want 00", o_checksum); else n_pass++;
`endif
  endtask

  task automatic test_load(input string name, input logic [7:0] base,
                           input logic [7:0] b0, input logic [7:0] b1,
                           input logic [7:0] b2, input logic [7:0] b3, input int len);
    logic [7:0] img [4];
    int la0, ld0, ex0, we0, oh0, us0, dn0, hl0;
    bit ok;
    ld_t e, o;
    img = '{b0, b1, b2, b3};
    do_reset();
    la0 = pulse_cnt[0]; ld0 = pulse_cnt[1]; ex0 = pulse_cnt[2];
    we0 = width_err; oh0 = onehot_err; us0 = unstable_err; dn0 = done_cnt; hl0 = halt_cnt;
    for (int i = 0; i < len; i++) begin
      exp_load.push_back({base + 8'(i), img[i]});
      stream_q.push_back('{b: img[i], delay: (i == 0) ? 3 : 0});
    end
    start_session(base, 9'(len));
    n_checks++;
    if (o_busy !== 1'b1) $display("FAIL %s_busy: got %b want 1", name, o_busy); else n_pass++;
    wait_done(600, ok);
    n_checks++;
    if (!ok) $display("FAIL %s_done: no o_done within 600 cycles", name); else n_pass++;
    n_checks++;
    if (o_busy !== 1'b0) $display("FAIL %s_busy_end: got %b want 0", name, o_busy); else n_pass++;
    tick(3);
    while (exp_load.size() > 0) begin
      e = exp_load.pop_front();
      n_checks++;
      if (obs_load.size() == 0)
        $display("FAIL %s_write: missing, want addr %h data %h", name, e.a, e.d);
      else begin
        o = obs_load.pop_front();
        if (o !== e) $display("FAIL %s_write: got addr %h data %h want addr %h data %h",
                              name, o.a, o.d, e.a, e.d);
        else n_pass++;
      end
    end
    n_checks++;
    if (obs_load.size() != 0) $display("FAIL %s_extra_writes: got %0d want 0", name, obs_load.size());
    else n_pass++;
    for (int i = 0; i < len; i++) begin
      n_checks++;
      if (cpu_ram[base + 8'(i)] !== img[i])
        $display("FAIL %s_ram: addr %h got %h want %h", name, base + 8'(i), cpu_ram[base + 8'(i)], img[i]);
      else n_pass++;
    end
    n_checks++;
    if ((pulse_cnt[0] - la0) != len || (pulse_cnt[1] - ld0) != len || (pulse_cnt[2] - ex0) != 1)
      $display("FAIL %s_pulses: got addr %0d data %0d exec %0d want %0d %0d 1", name,
               pulse_cnt[0] - la0, pulse_cnt[1] - ld0, pulse_cnt[2] - ex0, len, len);
    else n_pass++;
    n_checks++;
    if (width_err != we0 || onehot_err != oh0 || unstable_err != us0)
      $display("FAIL %s_strobe_shape: got width %0d onehot %0d unstable %0d errors want 0", name,
               width_err - we0, onehot_err - oh0, unstable_err - us0);
    else n_pass++;
    n_checks++;
    if ((done_cnt - dn0) != 1 || (halt_cnt - hl0) != 1)
      $display("FAIL %s_done_count: got done %0d halt %0d want 1 1", name, done_cnt - dn0, halt_cnt - hl0);
    else n_pass++;
  endtask

  task automatic test_len_zero();
    int la0, ld0, ex0, rd0, dn0;
    bit ok;
    do_reset();
    la0 = pulse_cnt[0]; ld0 = pulse_cnt[1]; ex0 = pulse_cnt[2]; rd0 = ready_cnt; dn0 = done_cnt;
    start_session(8'h30, 9'd0);
    wait_done(200, ok);
    tick(3);
    n_checks++;
    if (!ok) $display("FAIL len0_done: no o_done within 200 cycles"); else n_pass++;
    n_checks++;
    if ((pulse_cnt[0] - la0) != 0 || (pulse_cnt[1] - ld0) != 0)
      $display("FAIL len0_load_strobes: got %0d/%0d want 0/0", pulse_cnt[0] - la0, pulse_cnt[1] - ld0);
    else n_pass++;
    n_checks++;
    if ((ready_cnt - rd0) != 0) $display("FAIL len0_ready: got %0d cycles want 0", ready_cnt - rd0);
    else n_pass++;
    n_checks++;
    if ((pulse_cnt[2] - ex0) != 1 || (done_cnt - dn0) != 1)
      $display("FAIL len0_exec_done: got exec %0d done %0d want 1 1", pulse_cnt[2] - ex0, done_cnt - dn0);
    else n_pass++;
  endtask

  task automatic test_wrim();
    logic [7:0] prog [3];
    int it0, early;
    bit ok, seen;
    logic [7:0] e, o;
    prog = '{8'h02, 8'h20, 8'h00};
    do_reset();
    it0 = pulse_cnt[3];
    for (int i = 0; i < 3; i++) stream_q.push_back('{b: prog[i], delay: 0});
    start_session(8'h00, 9'd3);
    seen = 1'b0;
    repeat (400) begin
      tick(1);
      if (i_cpu_waiting && i_cpu_take_input) begin seen = 1'b1; break; end
    end
    n_checks++;
    if (!seen) $display("FAIL wrim_request: cpu never raised WRIM within 400 cycles"); else n_pass++;
    early = 0;
    repeat (10) begin tick(1); if (o_input_taken) early++; end
    n_checks++;
    if (early != 0) $display("FAIL wrim_stall: input_taken high %0d cycles want 0", early); else n_pass++;
    n_checks++;
    if (o_byte_ready !== 1'b1) $display("FAIL wrim_ready: got %b want 1", o_byte_ready); else n_pass++;
    exp_in.push_back(8'h5A);
    stream_q.push_back('{b: 8'h5A, delay: 0});
    wait_done(200, ok);
    tick(3);
    n_checks++;
    if (!ok) $display("FAIL wrim_done: no o_done within 200 cycles"); else n_pass++;
    while (exp_in.size() > 0) begin
      e = exp_in.pop_front();
      n_checks++;
      if (obs_in.size() == 0) $display("FAIL wrim_byte: missing, want %h", e);
      else begin
        o = obs_in.pop_front();
        if (o !== e) $display("FAIL wrim_byte: got %h want %h", o, e); else n_pass++;
      end
    end
    n_checks++;
    if ((pulse_cnt[3] - it0) != 1) $display("FAIL wrim_pulses: got %0d want 1", pulse_cnt[3] - it0);
    else n_pass++;
    n_checks++;
    if (cpu_ram[8'h20] !== 8'h5A) $display("FAIL wrim_ram: got %h want 5a", cpu_ram[8'h20]); else n_pass++;
  endtask

  task automatic test_reset_mid();
    int dn0, bad;
    bit seen;
    ld_t o;
    do_reset();
    clr_ram_on_reset = 1'b0;
    dn0 = done_cnt;
    stream_q.push_back('{b: 8'h11, delay: 0});
    stream_q.push_back('{b: 8'h22, delay: 0});
    stream_q.push_back('{b: 8'h33, delay: 0});
    start_session(8'h40, 9'd3);
    seen = 1'b0;
    repeat (200) begin tick(1); if (o_load_data) begin seen = 1'b1; break; end end
    // a start while busy must not restart the session at 8'h80
    i_base_addr = 8'h80; i_len = 9'd1; i_start = 1'b1;
    tick(1);
    i_start = 1'b0;
    repeat (200) begin tick(1); if (!o_load_data) break; end
    seen = 1'b0;
    repeat (200) begin tick(1); if (o_load_data) begin seen = 1'b1; break; end end
    n_checks++;
    if (!seen) $display("FAIL midrst_second_dhold: not reached within budget"); else n_pass++;
    tick(1);                            // still in D_HOLD, second cycle
    i_reset = 1'b1;
    tick(1);
    n_checks++;
    if ({o_byte_ready, o_load_addr, o_load_data, o_execute, o_input_taken, o_busy, o_done} !== 7'b0)
      $display("FAIL midrst_outputs: got %b want 0000000",
               {o_byte_ready, o_load_addr, o_load_data, o_execute, o_input_taken, o_busy, o_done});
    else n_pass++;
    i_reset = 1'b0;
    bad = 0;
    repeat (20) begin tick(1); if (o_busy || o_byte_ready) bad++; end
    n_checks++;
    if ((done_cnt - dn0) != 0 || bad != 0)
      $display("FAIL midrst_quiet: got done %0d busy/ready %0d want 0 0", done_cnt - dn0, bad);
    else n_pass++;
    n_checks++;
    if (obs_load.size() != 2) $display("FAIL midrst_writes: got %0d want 2", obs_load.size());
    else begin
      o = obs_load[1];
      if (o !== {8'h41, 8'h22}) $display("FAIL midrst_writes: got %h:%h want 41:22", o.a, o.d);
      else n_pass++;
    end
    n_checks++;
    if (cpu_ram[8'h40] !== 8'h11 || cpu_ram[8'h41] !== 8'h22 || cpu_ram[8'h80] !== 8'h00)
      $display("FAIL midrst_ram: got %h %h %h want 11 22 00",
               cpu_ram[8'h40], cpu_ram[8'h41], cpu_ram[8'h80]);
    else n_pass++;
    clr_ram_on_reset = 1'b1;
  endtask

`ifdef PROG_LOADER_CHECKSUM_EN
  task automatic test_checksum();
    bit ok;
    do_reset();
    stream_q.push_back('{b: 8'hFF, delay: 0});
    stream_q.push_back('{b: 8'h02, delay: 0});
    start_session(8'h60, 9'd2);
    wait_done(300, ok);
    n_checks++;
    if (!ok || o_checksum !== 8'h01)
      $display("FAIL checksum: got %h (done %b) want 01", o_checksum, ok);
    else n_pass++;
  endtask
`endif

  initial begin
    test_reset();
    test_load("basic", 8'h10, 8'h01, 8'h02, 8'h00, 8'h00, 3);
    test_load("wrap",  8'hFE, 8'hAA, 8'hBB, 8'h00, 8'hCC, 4);
    test_len_zero();
    test_wrim();
    test_reset_mid();
`ifdef PROG_LOADER_CHECKSUM_EN
    test_checksum();
`endif
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
